// File: rtl/sr_latch_driver.sv
// Valid/ready command front-end that turns set/reset requests into mutually exclusive S/R pulses.
// Optional Q/nQ readback after each pulse is compiled in with `define READBACK_CHECK_EN.
module sr_latch_driver #(
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned GAP_W   = 1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic cmd_valid_i,
    input  logic cmd_op_i,
    output logic cmd_ready_o,
    output logic S_o,
    output logic R_o,
    output logic busy_o,
    output logic done_o,
    input  logic q_i,
    input  logic nq_i,
    input  logic err_clr_i,
    output logic err_o
);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP,
        CHECK
    } state_t;

    localparam int unsigned PW_EFF = (PULSE_W == 0) ? 1 : PULSE_W;
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PW_EFF - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'((GAP_W == 0) ? 0 : GAP_W - 1);

`ifdef READBACK_CHECK_EN
    localparam bit     CHECK_EN   = 1'b1;
    localparam state_t TAIL_STATE = CHECK;
`else
    localparam bit     CHECK_EN   = 1'b0;
    localparam state_t TAIL_STATE = IDLE;
`endif
    // CHECK lasts two cycles: loaded with 1, compared when it reaches 0.
    localparam logic [CNT_W-1:0] TAIL_LD = CNT_W'(CHECK_EN ? 1 : 0);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ready_q;
    logic             s_q;
    logic             r_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

`ifdef READBACK_CHECK_EN
    logic op_q;
    logic q_s1_q, q_s2_q;
    logic nq_s1_q, nq_s2_q;
    logic mismatch_d;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            q_s1_q  <= 1'b0;
            q_s2_q  <= 1'b0;
            nq_s1_q <= 1'b0;
            nq_s2_q <= 1'b0;
        end else begin
            q_s1_q  <= q_i;
            q_s2_q  <= q_s1_q;
            nq_s1_q <= nq_i;
            nq_s2_q <= nq_s1_q;
        end
    end

    assign mismatch_d = (q_s2_q != op_q) || (nq_s2_q != ~op_q);
`else
    logic unused_inputs;
    assign unused_inputs = ^{q_i, nq_i, err_clr_i};
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef READBACK_CHECK_EN
            op_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef READBACK_CHECK_EN
            if (err_clr_i) begin
                err_q <= 1'b0;
            end
`endif
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (cmd_valid_i && ready_q) begin
                        state_q <= PULSE;
                        cnt_q   <= PULSE_LD;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        s_q     <= cmd_op_i;
                        r_q     <= ~cmd_op_i;
`ifdef READBACK_CHECK_EN
                        op_q    <= cmd_op_i;
`endif
                    end
                end

                PULSE: begin
                    if (cnt_q == '0) begin
                        s_q <= 1'b0;
                        r_q <= 1'b0;
                        if (GAP_W != 0) begin
                            state_q <= GAP;
                            cnt_q   <= GAP_LD;
                        end else begin
                            // No gap: go straight to the readback check or completion.
                            state_q <= TAIL_STATE;
                            cnt_q   <= TAIL_LD;
                            busy_q  <= CHECK_EN;
                            done_q  <= ~CHECK_EN;
                            ready_q <= ~CHECK_EN;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                GAP: begin
                    if (cnt_q == '0) begin
                        state_q <= TAIL_STATE;
                        cnt_q   <= TAIL_LD;
                        busy_q  <= CHECK_EN;
                        done_q  <= ~CHECK_EN;
                        ready_q <= ~CHECK_EN;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                CHECK: begin
`ifdef READBACK_CHECK_EN
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        // A mismatch overrides a simultaneous clear request.
                        if (mismatch_d) begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
`else
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
`endif
                end

                default: begin
                    state_q <= IDLE;
                    s_q     <= 1'b0;
                    r_q     <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready_o = ready_q;
    assign S_o         = s_q;
    assign R_o         = r_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver (PULSE_W=2, GAP_W=1); readback section runs when
// READBACK_CHECK_EN is defined, the cycle table otherwise.
module tb_sr_latch_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn  = 1'b1;
    logic valid = 1'b0;
    logic op    = 1'b0;
    logic q     = 1'b0;
    logic nq    = 1'b0;
    logic clr   = 1'b0;
    logic ready, s_out, r_out, busy, done, err;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    sr_latch_driver #(
        .PULSE_W(2),
        .GAP_W  (1),
        .CNT_W  (8)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .cmd_valid_i(valid),
        .cmd_op_i   (op),
        .cmd_ready_o(ready),
        .S_o        (s_out),
        .R_o        (r_out),
        .busy_o     (busy),
        .done_o     (done),
        .q_i        (q),
        .nq_i       (nq),
        .err_clr_i  (clr),
        .err_o      (err)
    );

    typedef struct {
        logic       rstn;
        logic       valid;
        logic       op;
        logic [5:0] exp;   // {err, ready, S, R, busy, done}
    } vec_t;

    vec_t tbl [21];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {2'b00, err, ready, s_out, r_out, busy, done};
    endfunction

    always @(negedge clk) begin
        if (s_out && r_out) begin
            n_bad++;
            $display("FAIL s_and_r: got S=%b R=%b, want never both 1", s_out, r_out);
        end
    end

`ifdef READBACK_CHECK_EN
    task automatic run_cmd(input logic cmd_op, output int unsigned lat);
        lat = 0;
        valid = 1'b1;
        op    = cmd_op;
        @(posedge clk); #1;
        valid = 1'b0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask
`endif

    initial begin
        int unsigned lat;
        lat = 0;
        #1 rstn = 1'b0;
        #2;
        check("reset_state", outs(), 8'b0);

`ifdef READBACK_CHECK_EN
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        check("ready_after_release", outs(), 8'b0001_0000);

        q = 1'b0; nq = 1'b1;
        run_cmd(1'b1, lat);
        check("chk_latency", 8'(lat), 8'd5);
        check("chk_err_set", outs(), 8'b0011_0001);
        @(posedge clk); #1;
        check("chk_err_sticky", outs(), 8'b0011_0000);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("chk_err_clear", outs(), 8'b0001_0000);

        q = 1'b1; nq = 1'b0;
        #30;
        run_cmd(1'b1, lat);
        check("chk_match_latency", 8'(lat), 8'd5);
        check("chk_match_noerr", outs(), 8'b0001_0001);

        q = 1'b1; nq = 1'b0;
        run_cmd(1'b0, lat);
        check("chk_reset_op_err", outs(), 8'b0011_0001);
        clr = 1'b1;
        @(posedge clk); #1;
        check("chk_clear_again", outs(), 8'b0001_0000);

        // Clear held through a failing command: the mismatch must win.
        q = 1'b0; nq = 1'b1;
        #30;
        run_cmd(1'b1, lat);
        check("chk_mismatch_beats_clr", outs(), 8'b0011_0001);
        clr = 1'b0;
`else
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 6'b000000};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 6'b010000};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 6'b001010};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 6'b001010};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 6'b000010};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 6'b010001};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 6'b000110};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 6'b000110};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 6'b000010};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 6'b010001};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 6'b001010};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 6'b001010};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 6'b000010};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 6'b010001};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 6'b010000};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 6'b001010};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 6'b001010};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 6'b000010};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 6'b010001};
        tbl[19] = '{1'b1, 1'b1, 1'b0, 6'b000110};
        tbl[20] = '{1'b1, 1'b0, 1'b0, 6'b000110};

        for (int i = 0; i < 21; i++) begin
            rstn  = tbl[i].rstn;
            valid = tbl[i].valid;
            op    = tbl[i].op;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), outs(), {2'b00, tbl[i].exp});
        end

        // Second cycle of the R pulse: asynchronous reset drops the drive at once.
        #2 rstn = 1'b0;
        #1;
        check("async_reset_drop", outs(), 8'b0);
        @(posedge clk); #1;
        check("reset_held", outs(), 8'b0);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("post_reset_idle%0d", i), outs(), 8'b0001_0000);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
